regfile_mbank: RTL

Parametrised multi-hart integer register file for the barrel-threaded core: HART_NUM banks of REG_NUM registers, two combinational read ports, two write ports (port 0 = ALU writeback, port 1 = late load return) and optional write-to-read bypass. Adds a per-hart bank-clear engine, used on hart (re)start, that zeroes one register per cycle. Replaces the fixed 2-hart, single-write-port bank in the decode/writeback stages.

---
 rtl/regfile_mbank_if.sv | 47 ++++
 rtl/regfile_mbank.sv | 159 +++++++++++++++
 2 files changed

// File: rtl/regfile_mbank_if.sv
// Register-file access bundle: two read ports, two write ports and the bank-clear handshake.
interface regfile_mbank_if #(
    parameter int unsigned XLEN     = 32,
    parameter int unsigned HART_NUM = 4,
    parameter int unsigned REG_NUM  = 32
);
    localparam int unsigned HART_ID_W  = $clog2(HART_NUM);
    localparam int unsigned REG_ADDR_W = $clog2(REG_NUM);

    logic [HART_ID_W-1:0]  r_hart_id;
    logic [REG_ADDR_W-1:0] raddr1;
    logic [REG_ADDR_W-1:0] raddr2;
    logic [XLEN-1:0]       rdata1;
    logic [XLEN-1:0]       rdata2;

    logic                  w0_en;
    logic [HART_ID_W-1:0]  w0_hart_id;
    logic [REG_ADDR_W-1:0] w0_addr;
    logic [XLEN-1:0]       w0_data;

    logic                  w1_en;
    logic [HART_ID_W-1:0]  w1_hart_id;
    logic [REG_ADDR_W-1:0] w1_addr;
    logic [XLEN-1:0]       w1_data;

    logic                  clr_req;
    logic [HART_ID_W-1:0]  clr_hart;
    logic                  clr_busy;
    logic                  clr_done;
    logic                  wr_conflict;

    modport master (
        output r_hart_id, raddr1, raddr2,
        output w0_en, w0_hart_id, w0_addr, w0_data,
        output w1_en, w1_hart_id, w1_addr, w1_data,
        output clr_req, clr_hart,
        input  rdata1, rdata2, clr_busy, clr_done, wr_conflict
    );

    modport slave (
        input  r_hart_id, raddr1, raddr2,
        input  w0_en, w0_hart_id, w0_addr, w0_data,
        input  w1_en, w1_hart_id, w1_addr, w1_data,
        input  clr_req, clr_hart,
        output rdata1, rdata2, clr_busy, clr_done, wr_conflict
    );
endinterface

// File: rtl/regfile_mbank.sv
// Multi-hart integer register file: per-hart banks, 2 read / 2 write ports,
// optional write-to-read bypass and a one-register-per-cycle bank-clear engine.
module regfile_mbank #(
    parameter int unsigned XLEN     = 32,
    parameter int unsigned HART_NUM = 4,
    parameter int unsigned REG_NUM  = 32,
    parameter bit          BYPASS   = 1'b1
) (
    input logic             clk,
    input logic             rst_n,
    regfile_mbank_if.slave  bus
);
    localparam int unsigned HART_ID_W  = $clog2(HART_NUM);
    localparam int unsigned REG_ADDR_W = $clog2(REG_NUM);
    localparam logic [REG_ADDR_W-1:0] LAST_IDX = REG_ADDR_W'(REG_NUM - 1);

    localparam logic [0:0] ST_IDLE  = 1'b0;
    localparam logic [0:0] ST_CLEAR = 1'b1;

    logic [XLEN-1:0]       regs [HART_NUM][REG_NUM];

    logic [0:0]            state;
    logic [0:0]            state_nxt;
    logic [HART_ID_W-1:0]  clr_hart_q;
    logic [HART_ID_W-1:0]  clr_hart_nxt;
    logic [REG_ADDR_W-1:0] idx;
    logic [REG_ADDR_W-1:0] idx_nxt;
    logic                  clr_done_nxt;

    logic                  clr_busy_q;
    logic                  clr_done_q;
    logic                  wr_conflict_q;

    logic                  clearing;
    logic                  w0_ok;
    logic                  w1_ok;
    logic                  conflict_c;

    // Clear FSM state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= ST_IDLE;
            clr_hart_q <= '0;
            idx        <= '0;
        end else begin
            state      <= state_nxt;
            clr_hart_q <= clr_hart_nxt;
            idx        <= idx_nxt;
        end
    end

    // Clear FSM next state: latch the bank, then walk idx 1..REG_NUM-1
    always_comb begin
        state_nxt    = state;
        clr_hart_nxt = clr_hart_q;
        idx_nxt      = idx;
        clr_done_nxt = 1'b0;
        case (state)
            ST_IDLE: begin
                if (bus.clr_req) begin
                    state_nxt    = ST_CLEAR;
                    clr_hart_nxt = bus.clr_hart;
                    idx_nxt      = REG_ADDR_W'(1);
                end
            end
            ST_CLEAR: begin
                idx_nxt = idx + REG_ADDR_W'(1);
                if (idx == LAST_IDX) begin
                    state_nxt    = ST_IDLE;
                    clr_done_nxt = 1'b1;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    assign clearing = (state == ST_CLEAR);

    // User writes to x0 or to the bank being cleared are dropped
    assign w0_ok = bus.w0_en && (bus.w0_addr != '0) &&
                   !(clearing && (bus.w0_hart_id == clr_hart_q));
    assign w1_ok = bus.w1_en && (bus.w1_addr != '0) &&
                   !(clearing && (bus.w1_hart_id == clr_hart_q));

    assign conflict_c = w0_ok && w1_ok &&
                        (bus.w0_hart_id == bus.w1_hart_id) &&
                        (bus.w0_addr == bus.w1_addr);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            clr_busy_q    <= 1'b0;
            clr_done_q    <= 1'b0;
            wr_conflict_q <= 1'b0;
        end else begin
            clr_busy_q    <= (state_nxt == ST_CLEAR);
            clr_done_q    <= clr_done_nxt;
            wr_conflict_q <= conflict_c;
        end
    end

    // Storage: clear engine beats w1, w1 beats w0
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned h = 0; h < HART_NUM; h++) begin
                for (int unsigned r = 0; r < REG_NUM; r++) begin
                    regs[h][r] <= '0;
                end
            end
        end else begin
            for (int unsigned h = 0; h < HART_NUM; h++) begin
                for (int unsigned r = 0; r < REG_NUM; r++) begin
                    if (clearing && (clr_hart_q == HART_ID_W'(h)) && (idx == REG_ADDR_W'(r))) begin
                        regs[h][r] <= '0;
                    end else if (w1_ok && (bus.w1_hart_id == HART_ID_W'(h)) &&
                                 (bus.w1_addr == REG_ADDR_W'(r))) begin
                        regs[h][r] <= bus.w1_data;
                    end else if (w0_ok && (bus.w0_hart_id == HART_ID_W'(h)) &&
                                 (bus.w0_addr == REG_ADDR_W'(r))) begin
                        regs[h][r] <= bus.w0_data;
                    end
                end
            end
        end
    end

    logic [REG_ADDR_W-1:0] raddr [2];
    logic [XLEN-1:0]       rdata [2];

    assign raddr[0] = bus.raddr1;
    assign raddr[1] = bus.raddr2;

    // Read mux; later assignments take precedence
    always_comb begin
        for (int p = 0; p < 2; p++) begin
            rdata[p] = regs[bus.r_hart_id][raddr[p]];
            if (BYPASS) begin
                if (w0_ok && (bus.w0_hart_id == bus.r_hart_id) && (bus.w0_addr == raddr[p])) begin
                    rdata[p] = bus.w0_data;
                end
                if (w1_ok && (bus.w1_hart_id == bus.r_hart_id) && (bus.w1_addr == raddr[p])) begin
                    rdata[p] = bus.w1_data;
                end
            end
            if (clearing && (bus.r_hart_id == clr_hart_q)) begin
                rdata[p] = '0;
            end
            if (raddr[p] == '0) begin
                rdata[p] = '0;
            end
        end
    end

    assign bus.rdata1      = rdata[0];
    assign bus.rdata2      = rdata[1];
    assign bus.clr_busy    = clr_busy_q;
    assign bus.clr_done    = clr_done_q;
    assign bus.wr_conflict = wr_conflict_q;

endmodule
